// File: rtl/icache_fetch_responder_pkg.sv
// Shared I-cache constants: address split widths, block width, fill-FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package icache_fetch_responder_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int WORD_SEL_W = 2;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2
    } state_t;

    // Block address of the refill in flight, latched when the miss is taken.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
    } blk_addr_t;

    function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_W-1:0] blk,
                                                  input logic [WORD_SEL_W-1:0] sel);
        return blk[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_fetch_responder_if.sv
// Fetch-port and instruction-memory bus bundle for the I-cache responder.
// Latency: n/a (wires only).
// Backpressure: BUSYWAIT stalls the CPU side, mem_busywait stalls the memory side.
interface icache_fetch_responder_if;
    import icache_fetch_responder_pkg::*;

    logic [31:0]            PC;
    logic [WORD_W-1:0]      INSTRUCTION;
    logic                   BUSYWAIT;
    logic [MEM_ADDR_W-1:0]  mem_address;
    logic                   mem_read;
    logic [BLOCK_W-1:0]     mem_readdata;
    logic                   mem_busywait;

    modport master (
        input  PC, mem_readdata, mem_busywait,
        output INSTRUCTION, BUSYWAIT, mem_address, mem_read
    );

    modport slave (
        output PC, mem_readdata, mem_busywait,
        input  INSTRUCTION, BUSYWAIT, mem_address, mem_read
    );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped I-cache: one write port, one combinational read port.
// Latency: reads combinational; writes land on the next posedge.
// Backpressure: none; the caller sequences writes.
module icache_line_array
    import icache_fetch_responder_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int TAG_BITS  = TAG_W
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          wr_vld,
    input  logic [$clog2(NUM_LINES)-1:0]  wr_index,
    input  logic [TAG_BITS-1:0]           wr_tag,
    input  logic [BLOCK_W-1:0]            wr_dat,
    input  logic [$clog2(NUM_LINES)-1:0]  rd_index,
    output logic                          rd_valid,
    output logic [TAG_BITS-1:0]           rd_tag,
    output logic [BLOCK_W-1:0]            rd_dat
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tags [NUM_LINES];
    logic [BLOCK_W-1:0]   data [NUM_LINES];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
        end else if (wr_vld) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data are never cleared; the valid bit alone guards them.
    always_ff @(posedge CLK) begin
        if (wr_vld) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_dat;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_dat   = data[rd_index];

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped I-cache serving the CPU PC->INSTRUCTION port from a 128-bit block memory; ICACHE_STATS_EN adds hit/miss counters.
// Latency: hits combinational (0 cycles); a miss stalls 2 cycles plus memory latency.
// Backpressure: BUSYWAIT holds the CPU during a refill; mem_busywait extends MEM_READ.
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int NUM_LINES  = 8,
    parameter int ADDR_W     = 10,
    parameter int WORD_SEL_W = 2
) (
    input  logic                          CLK,
    input  logic                          RESET,
    icache_fetch_responder_if.master      bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                   hit_count,
    output logic [15:0]                   miss_count
`endif
);

    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_W - IDX_W - WORD_SEL_W - 2;

    logic [TAG_BITS-1:0]   pc_tag;
    logic [IDX_W-1:0]      pc_index;
    logic [WORD_SEL_W-1:0] pc_word;
    logic                  unused_pc;

    assign pc_tag    = bus.PC[ADDR_W-1 -: TAG_BITS];
    assign pc_index  = bus.PC[2+WORD_SEL_W +: IDX_W];
    assign pc_word   = bus.PC[2 +: WORD_SEL_W];
    assign unused_pc = ^{bus.PC[31:ADDR_W], bus.PC[1:0]};

    state_t             state, state_nxt;
    blk_addr_t          req;
    logic [BLOCK_W-1:0] fill_dat;

    logic               rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [BLOCK_W-1:0] rd_dat;
    logic               hit;

    logic               busy;
    logic               rd_req;
    logic [WORD_W-1:0]  instr;
    logic               lookup_hit;
    logic               miss_start;
    logic               fill_wr;
    logic               fill_capture;

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_BITS  (TAG_BITS)
    ) u_lines (
        .CLK      (CLK),
        .RESET    (RESET),
        .wr_vld   (fill_wr),
        .wr_index (req.index),
        .wr_tag   (req.tag),
        .wr_dat   (fill_dat),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_dat   (rd_dat)
    );

    assign hit          = rd_valid && (rd_tag == pc_tag);
    assign fill_capture = (state == ST_MEM_READ) && !bus.mem_busywait;

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        rd_req     = 1'b0;
        instr      = '0;
        lookup_hit = 1'b0;
        miss_start = 1'b0;
        fill_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    instr      = word_of(rd_dat, pc_word);
                    lookup_hit = 1'b1;
                end else begin
                    busy       = 1'b1;
                    miss_start = 1'b1;
                    state_nxt  = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                rd_req = 1'b1;
                busy   = 1'b1;
                if (!bus.mem_busywait) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                busy      = 1'b1;
                fill_wr   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset must release the CPU and the memory immediately, not at the next edge.
        if (!RESET) begin
            busy   = 1'b0;
            rd_req = 1'b0;
            instr  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            req      <= '0;
            fill_dat <= '0;
        end else begin
            state <= state_nxt;
            if (miss_start) begin
                req.tag   <= pc_tag;
                req.index <= pc_index;
            end
            if (fill_capture) begin
                fill_dat <= bus.mem_readdata;
            end
        end
    end

    assign bus.INSTRUCTION = instr;
    assign bus.BUSYWAIT    = busy;
    assign bus.mem_read    = rd_req;
    assign bus.mem_address = req;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (lookup_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
